// File: rtl/rr_arb4way16_pkg.sv
// Shared types, constants and round-robin helpers for the rr_arb4way16 arbiter.
package rr_arb4way16_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;

    // First set bit of req scanning ptr, ptr+1, ... wrapping mod NREQ.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arb4way16_if.sv
// Request/data/grant bundle between four requesters and the arbiter.
interface rr_arb4way16_if #(
    parameter int unsigned WIDTH = 16
);
    logic [3:0]       req;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output req, i0, i1, i2, i3,
        input  gnt, sel, out, out_valid
    );

    modport slave (
        input  req, i0, i1, i2, i3,
        output gnt, sel, out, out_valid
    );
endinterface

// File: rtl/rr_arb4way16_mux.sv
// Combinational four-way word multiplexer driven by the arbiter's select.
module mux4way16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);
    always_comb begin
        out = '0;
        case (sel)
            2'd0:    out = i0;
            2'd1:    out = i1;
            2'd2:    out = i2;
            default: out = i3;
        endcase
    end
endmodule

// File: rtl/rr_arb4way16.sv
// Round-robin arbiter owning the mux select; registers the granted requester's word.
module rr_arb4way16 #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb4way16_if.slave bus
);
    import rr_arb4way16_pkg::*;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    arb_state_t       state;
    logic [1:0]       ptr;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] mux_word;

    logic [3:0] others;
    logic [3:0] cnt_inc;
    logic       expired;
    logic       release_now;
    logic [1:0] next_ptr;
    logic [1:0] idle_pick;
    logic [1:0] hand_pick;

    mux4way16 #(.WIDTH(WIDTH)) u_mux (
        .i0  (bus.i0),
        .i1  (bus.i1),
        .i2  (bus.i2),
        .i3  (bus.i3),
        .sel (bus.sel),
        .out (mux_word)
    );

    // Owner drop and hold expiry on the same edge collapse into one release.
    always_comb begin
        others      = bus.req & ~bus.gnt;
        expired     = (32'(cnt) + 32'd1) >= HOLD_MAX;
        cnt_inc     = expired ? HOLD_LIM : cnt + 4'd1;
        release_now = !bus.req[bus.sel] || (expired && (others != '0));
        next_ptr    = bus.sel + 2'd1;
        idle_pick   = rr_pick(bus.req, ptr);
        hand_pick   = rr_pick(others, next_ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.sel       <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.out_valid <= 1'b0;
                    if (bus.req != '0) begin
                        bus.gnt <= onehot(idle_pick);
                        bus.sel <= idle_pick;
                        cnt     <= '0;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    bus.out       <= mux_word;
                    bus.out_valid <= 1'b1;
                    cnt           <= cnt_inc;
                    if (release_now) begin
                        ptr <= next_ptr;
                        if (others != '0) begin
                            bus.gnt <= onehot(hand_pick);
                            bus.sel <= hand_pick;
                            cnt     <= '0;
                        end else begin
                            bus.gnt <= '0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arb4way16.sv
// Directed bench for rr_arb4way16: vector table plus hand-written multi-cycle sequences.
module tb_rr_arb4way16;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rr_arb4way16_if #(.WIDTH(16)) bus ();

    rr_arb4way16 #(.WIDTH(16), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic [15:0] out;
        logic        ov;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] data[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                                input logic [1:0] s, input logic [15:0] o, input logic v);
        vec_t e;
        e.rst = r; e.req = q; e.gnt = g; e.sel = s; e.out = o; e.ov = v;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic [15:0] o, input logic v);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
        chk({tag, ".out"}, 32'(bus.out), 32'(o));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        data[0] = 16'hAAAA; data[1] = 16'hBBBB; data[2] = 16'hCCCC; data[3] = 16'hDDDD;
        bus.i0 = data[0]; bus.i1 = data[1]; bus.i2 = data[2]; bus.i3 = data[3];
        bus.req = '0;
        rst_n   = 1'b0;
        #2;
        chk_all("reset", 4'b0000, 2'd0, 16'h0000, 1'b0);

        // Single requester 1: 2-cycle latency, release at E4, valid drops after E5.
        add(1, 4'b0010, 4'b0010, 2'd1, 16'h0000, 0);
        for (int n = 0; n < 3; n++) add(0, 4'b0010, 4'b0010, 2'd1, 16'hBBBB, 1);
        add(0, 4'b0000, 4'b0000, 2'd1, 16'hBBBB, 1);
        add(0, 4'b0000, 4'b0000, 2'd1, 16'hBBBB, 0);
        // All four continuously: HOLD_MAX cycles each, data trails grant by one edge.
        add(1, 4'b1111, 4'b0001, 2'd0, 16'h0000, 0);
        for (int n = 1; n < 20; n++) begin
            int o;
            o = (n / 4) % 4;
            add(0, 4'b1111, 4'(1 << o), 2'(o), data[((n - 1) / 4) % 4], 1);
        end

        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].rst) do_reset();
            bus.req = vecs[v].req;
            tick();
            chk_all($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].sel, vecs[v].out, vecs[v].ov);
        end

        // Lone requester 3 held 20 cycles, then requester 0 takes over on expiry.
        do_reset();
        bus.req = 4'b1000;
        tick();
        chk("hold3.first_gnt", 32'(bus.gnt), 32'h8);
        for (int n = 1; n < 20; n++) begin
            tick();
            chk($sformatf("hold3.gnt%0d", n), 32'(bus.gnt), 32'h8);
            chk($sformatf("hold3.out%0d", n), 32'(bus.out), 32'hDDDD);
        end
        bus.req = 4'b1001;
        tick();
        chk_all("hold3.handoff", 4'b0001, 2'd0, 16'hDDDD, 1'b1);
        tick();
        chk_all("hold3.after", 4'b0001, 2'd0, 16'hAAAA, 1'b1);

        // Owner 0 drops with requester 2 waiting: no idle bubble.
        do_reset();
        bus.req = 4'b0101;
        tick();
        chk("gap.first", 32'(bus.gnt), 32'h1);
        tick();
        chk_all("gap.own0", 4'b0001, 2'd0, 16'hAAAA, 1'b1);
        bus.req = 4'b0100;
        tick();
        chk_all("gap.switch", 4'b0100, 2'd2, 16'hAAAA, 1'b1);
        tick();
        chk_all("gap.data2", 4'b0100, 2'd2, 16'hCCCC, 1'b1);

        // Asynchronous reset mid-grant of requester 2, then scan restarts at 0.
        rst_n = 1'b0;
        #1;
        chk_all("areset", 4'b0000, 2'd0, 16'h0000, 1'b0);
        #3;
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        tick();
        chk("areset.regrant", 32'(bus.gnt), 32'h1);

        // Owner 1 drops on its last hold cycle: one handoff, scan from 2 picks 3 over 0.
        do_reset();
        bus.req = 4'b0010;
        tick();
        chk("same.first", 32'(bus.gnt), 32'h2);
        bus.req = 4'b1011;
        for (int n = 1; n < 4; n++) begin
            tick();
            chk($sformatf("same.hold%0d", n), 32'(bus.gnt), 32'h2);
        end
        bus.req = 4'b1001;
        tick();
        chk_all("same.handoff", 4'b1000, 2'd3, 16'hBBBB, 1'b1);
        tick();
        chk_all("same.data3", 4'b1000, 2'd3, 16'hDDDD, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
